// File: rtl/mem_port_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single shared memory port.
// Define ARB_ROUND_ROBIN_EN for alternating tie-break; default is data-wins fixed priority.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ACC_I, ACC_D, RESP} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    // 1 = data port won the most recent grant; also selects which ack fires in RESP
    logic              last_grant_d;
    logic              grant_d;
    logic              grant_i;

    always_comb begin
`ifdef ARB_ROUND_ROBIN_EN
        grant_d = d_req && (!if_req || !last_grant_d);
`else
        grant_d = d_req;
`endif
        grant_i = if_req && !grant_d;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_d)      state_nxt = ACC_D;
                else if (grant_i) state_nxt = ACC_I;
            end
            ACC_I, ACC_D: begin
                if (mem_ready) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if_ack    = 1'b0;
        d_ack     = 1'b0;
        busy      = (state != IDLE);
        case (state)
            ACC_I: begin
                mem_en    = 1'b1;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            ACC_D: begin
                mem_en    = 1'b1;
                mem_we    = we_q;
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
            end
            RESP: begin
                if_ack = !last_grant_d;
                d_ack  = last_grant_d;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            last_grant_d <= 1'b0;
            if_rdata     <= '0;
            d_rdata      <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && (grant_d || grant_i))
                last_grant_d <= grant_d;
            if (state == ACC_I && mem_ready)
                if_rdata <= mem_rdata;
            // stores complete with d_ack but leave the last load result in place
            if (state == ACC_D && mem_ready && !we_q)
                d_rdata <= mem_rdata;
        end
    end

    // Access parameters are captured once at grant; requester inputs are ignored afterwards.
    always_ff @(posedge clk) begin
        if (state == IDLE) begin
            if (grant_d) begin
                addr_q  <= d_addr;
                we_q    <= d_we;
                wdata_q <= d_wdata;
            end else if (grant_i) begin
                addr_q  <= if_addr;
                we_q    <= 1'b0;
                wdata_q <= '0;
            end
        end
    end

endmodule
